// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared types for the snooping bus: bus and crossbar messages, arbiter
// state encoding, CPU index type and small helpers used by the arbiter.
package snoop_bus_arbiter_pkg;

   localparam int NUM_CPUS  = 4;
   localparam int CPU_IDX_W = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;
   localparam int ADDR_W    = 8;

   typedef logic [CPU_IDX_W-1:0] cpu_idx_t;

   typedef enum logic [1:0] {
      BusGetS = 2'd0,
      BusGetM = 2'd1,
      BusUpg  = 2'd2,
      BusInv  = 2'd3
   } bus_tx_t;

   typedef struct packed {
      logic              valid;
      bus_tx_t           bus_tx;
      cpu_idx_t          source;
      logic [ADDR_W-1:0] addr;
   } bus_msg_t;

   typedef struct packed {
      logic              valid;
      logic              writeback;
      cpu_idx_t          destination;
      logic [ADDR_W-1:0] addr;
   } xbar_msg_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BCAST = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   // Only GetS/GetM pull data across the crossbar; upgrades and
   // invalidates finish as soon as they have been broadcast.
   function automatic logic needs_data(input bus_tx_t tx);
      return (tx == BusGetS) || (tx == BusGetM);
   endfunction

   function automatic logic [NUM_CPUS-1:0] cpu_onehot(input cpu_idx_t idx);
      logic [NUM_CPUS-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

   function automatic cpu_idx_t next_cpu(input cpu_idx_t idx);
      if (idx == cpu_idx_t'(NUM_CPUS - 1)) begin
         return '0;
      end else begin
         return idx + cpu_idx_t'(1);
      end
   endfunction

endpackage

// File: rtl/snoop_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first set bit of 'valid'
// scanning ptr, ptr+1, ... modulo N. Generic so the crossbar can reuse it.
module snoop_bus_arbiter_rr_picker #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     valid,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic             found_s;
   logic [IDX_W-1:0] idx_s;
   int               sum_s;

   // Scan from the pointer with wrap-around and keep the first hit.
   always_comb begin
      found_s = 1'b0;
      idx_s   = '0;
      sum_s   = 0;
      for (int k = 0; k < N; k++) begin
         sum_s = int'(ptr) + k;
         if (sum_s >= N) begin
            sum_s = sum_s - N;
         end else begin
            sum_s = sum_s;
         end
         if (!found_s && valid[sum_s[IDX_W-1:0]]) begin
            found_s = 1'b1;
            idx_s   = sum_s[IDX_W-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   assign found = found_s;
   assign idx   = idx_s;

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared snooping bus. One coherence
// transaction is outstanding at a time: IDLE picks a requester, BCAST drives
// its message for one cycle, WAIT holds the bus until the data response for
// that transaction shows up on the crossbar.
// Optional build macro SNOOP_BUS_WDOG_EN bounds WAIT to WDOG_CYCLES cycles
// and reports an abort on wdog_err; without it WAIT is unbounded.
module snoop_bus_arbiter
   import snoop_bus_arbiter_pkg::*;
#(
   parameter int WDOG_CYCLES = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  bus_msg_t            bus_req [NUM_CPUS],
   output logic [NUM_CPUS-1:0] bus_gnt,
   output bus_msg_t            bus_msg,
   input  xbar_msg_t           xbar_resp,
   output logic                bus_busy,
   output logic                wdog_err
);

   arb_state_t          state_r;
   cpu_idx_t            rr_ptr_r;
   cpu_idx_t            owner_r;
   bus_tx_t             lat_tx_r;
   logic [ADDR_W-1:0]   lat_addr_r;
   bus_msg_t            bus_msg_r;
   logic [NUM_CPUS-1:0] bus_gnt_r;
   logic                bus_busy_r;
   logic                wdog_err_r;

   logic [NUM_CPUS-1:0] req_valid_s;
   logic                found_s;
   cpu_idx_t            pick_idx_s;
   bus_msg_t            sel_msg_s;
   logic                match_s;
   logic                wdog_hit_s;

   // Gather the per-CPU valid bits for the picker.
   always_comb begin
      req_valid_s = '0;
      for (int i = 0; i < NUM_CPUS; i++) begin
         req_valid_s[i] = bus_req[i].valid;
      end
   end

   snoop_bus_arbiter_rr_picker #(
      .N     (NUM_CPUS),
      .IDX_W (CPU_IDX_W)
   ) u_rr_picker (
      .valid (req_valid_s),
      .ptr   (rr_ptr_r),
      .found (found_s),
      .idx   (pick_idx_s)
   );

   // Message to broadcast for the picked requester; the source field is
   // forced to the winning index so snoopers never trust the requester.
   always_comb begin
      sel_msg_s        = bus_req[pick_idx_s];
      sel_msg_s.source = pick_idx_s;
      sel_msg_s.valid  = 1'b1;
   end

   // A data delivery to the owner for the owned address completes the
   // transaction; writebacks to the same line are unrelated traffic.
   always_comb begin
      match_s = xbar_resp.valid && !xbar_resp.writeback &&
                (xbar_resp.destination == owner_r) &&
                (xbar_resp.addr == lat_addr_r);
   end

`ifdef SNOOP_BUS_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

   logic [WDOG_W-1:0] wdog_cnt_r;

   assign wdog_hit_s = (state_r == WAIT) &&
                       (wdog_cnt_r == WDOG_W'(WDOG_CYCLES - 1));

   // Count WAIT cycles; restart for every new broadcast and after an abort.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog_cnt_r <= '0;
      end else if ((state_r == IDLE) && found_s) begin
         wdog_cnt_r <= '0;
      end else if (state_r == WAIT) begin
         if (wdog_hit_s) begin
            wdog_cnt_r <= '0;
         end else begin
            wdog_cnt_r <= wdog_cnt_r + WDOG_W'(1);
         end
      end else begin
         wdog_cnt_r <= wdog_cnt_r;
      end
   end
`else
   // WAIT never times out; any legal (positive) limit folds this to 0.
   assign wdog_hit_s = (WDOG_CYCLES < 0);
`endif

   // Bus sequencer FSM with registered grant, message, busy and abort outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= IDLE;
         rr_ptr_r   <= '0;
         owner_r    <= '0;
         lat_tx_r   <= BusGetS;
         lat_addr_r <= '0;
         bus_msg_r  <= '0;
         bus_gnt_r  <= '0;
         bus_busy_r <= 1'b0;
         wdog_err_r <= 1'b0;
      end else begin
         bus_gnt_r  <= '0;
         bus_msg_r  <= '0;
         wdog_err_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (found_s) begin
                  owner_r    <= pick_idx_s;
                  lat_tx_r   <= sel_msg_s.bus_tx;
                  lat_addr_r <= sel_msg_s.addr;
                  bus_msg_r  <= sel_msg_s;
                  bus_gnt_r  <= cpu_onehot(pick_idx_s);
                  bus_busy_r <= 1'b1;
                  state_r    <= BCAST;
               end else begin
                  bus_busy_r <= 1'b0;
                  state_r    <= IDLE;
               end
            end
            BCAST: begin
               rr_ptr_r <= next_cpu(owner_r);
               if (!needs_data(lat_tx_r) || match_s) begin
                  bus_busy_r <= 1'b0;
                  state_r    <= IDLE;
               end else begin
                  bus_busy_r <= 1'b1;
                  state_r    <= WAIT;
               end
            end
            WAIT: begin
               if (match_s) begin
                  bus_busy_r <= 1'b0;
                  state_r    <= IDLE;
               end else if (wdog_hit_s) begin
                  bus_busy_r <= 1'b0;
                  wdog_err_r <= 1'b1;
                  state_r    <= IDLE;
               end else begin
                  bus_busy_r <= 1'b1;
                  state_r    <= WAIT;
               end
            end
            default: begin
               bus_busy_r <= 1'b0;
               state_r    <= IDLE;
            end
         endcase
      end
   end

   assign bus_gnt  = bus_gnt_r;
   assign bus_msg  = bus_msg_r;
   assign bus_busy = bus_busy_r;
   assign wdog_err = wdog_err_r;

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared snooping bus between NUM_CPUS cache controllers and memory.
- Picks one requester, broadcasts its bus_msg_t for exactly one cycle, then holds the bus until the data response for that transaction appears on the crossbar.
- Guarantees one outstanding coherence transaction at a time, so snoopers and memory see a serialized bus_msg stream.

Parameters:
- NUM_CPUS, from types package (4): number of requesters.
- WDOG_CYCLES, 64: wait-state cycle limit before abort; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- bus_req[NUM_CPUS]  in  bus_msg_t  per-CPU request; valid held until granted; fields stable while valid
- bus_gnt  out  NUM_CPUS  one-hot grant pulse, asserted in the broadcast cycle only
- bus_msg  out  bus_msg_t  broadcast to snoopers and memory
- xbar_resp  in  xbar_msg_t  crossbar delivery monitor: memory or cache data to a destination
- bus_busy  out  1  high in BCAST and WAIT
- wdog_err  out  1  one-cycle abort pulse; tied 0 without the feature

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, rr_ptr=0, owner=0, latched msg cleared, wdog counter=0. All outputs are 0: bus_msg='0, bus_gnt='0, bus_busy=0, wdog_err=0.
- State IDLE:
  - If any bus_req[i].valid, select the first valid index scanning rr_ptr, rr_ptr+1, … modulo NUM_CPUS.
  - Latch owner=i, bus_req[i], and force the latched source field to i.
  - Go to BCAST. Nothing is broadcast in IDLE.
- State BCAST (exactly one cycle):
  - bus_msg = latched msg with valid=1; bus_gnt[owner]=1; rr_ptr <= owner+1 (wraps at NUM_CPUS).
  - If bus_tx is not BusGetS or BusGetM (upgrade or invalidate-only), the transaction completes and the next state is IDLE.
  - Else if a matching response is present this same cycle, the next state is IDLE. Memory replies combinationally, so this is the common case.
  - Otherwise the next state is WAIT.
- Matching response: xbar_resp.valid && !xbar_resp.writeback && destination==owner && addr==latched addr.
- State WAIT:
  - bus_msg.valid=0, so memory does not re-respond; bus_busy=1.
  - On a matching response, go to IDLE. Non-matching traffic, including writebacks, is ignored.
- New requests are sampled only in IDLE, so back-to-back transactions have a minimum 2-cycle period (IDLE, BCAST).
- A requester drops valid on the cycle after its bus_gnt pulse. A valid that is still high afterwards is a new request.
- Fairness: with all CPUs requesting continuously, grants rotate 0,1,…,NUM_CPUS-1,0.
- A request that deasserts before grant is legal; it simply is not selected.
- Reset asserted mid-WAIT aborts the transaction; no response is expected afterwards.

Optional Feature:
- Macro: SNOOP_BUS_WDOG_EN.
- With the macro defined:
  - A counter increments each WAIT cycle.
  - On reaching WDOG_CYCLES, the arbiter goes to IDLE, pulses wdog_err for 1 cycle, and clears the counter.
  - The counter also clears on entry to BCAST.
- Without the macro: no counter, wdog_err constant 0, and WAIT is unbounded.

Decomposition:
- types package additions: arb_state_t enum {IDLE, BCAST, WAIT}, and a cpu_idx_t typedef of width $clog2(NUM_CPUS).
- WDOG_CYCLES stays a module parameter.
- Sub-module rr_picker: combinational, takes the valid vector plus rr_ptr and returns found plus index. It is natural to split out and reuse in the crossbar.

Test Plan:
- CPU2 BusGetS addr 0x5 and memory answers in the same cycle → bus_gnt=4'b0100 for 1 cycle, bus_msg.valid for 1 cycle with source=2, back to IDLE, bus_busy high for 1 cycle.
- All 4 CPUs request BusGetM continuously → grant order 0,1,2,3,0, one grant every 2 cycles.
- CPU1 request with the response delayed 5 cycles (cache-supplied) → bus_busy high for 6 cycles. A writeback to addr 0x5 and a response to destination 3 during WAIT do not complete it. The matching response to CPU1 returns to IDLE.
- CPU0 BusUpg → completes in BCAST without any xbar response; the next request is granted 2 cycles later.
- rst driven low asynchronously mid-WAIT → outputs 0 immediately; after release, the first grant goes to CPU0 when all request.
- SNOOP_BUS_WDOG_EN, WDOG_CYCLES=8, no response ever → wdog_err pulses after 8 WAIT cycles and the next pending request is granted.
